keypad_scan: RTL and testbench



---
 rtl/nonogram_pkg.sv | 37 +++
 rtl/keypad_sync.sv | 24 ++
 rtl/keypad_scan.sv | 182 ++++++++++++++++++
 tb/tb_keypad_scan.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/nonogram_pkg.sv
// Shared nonogram front-end definitions: 5-bit key_pulse codes, keypad scanner
// states and the 4x4 keypad code map. Consumed by keypad_scan and the controller.
package nonogram_pkg;

    localparam logic [4:0] KEY_NONE = 5'b00000;
    localparam logic [4:0] KEY_0    = 5'b10000;
    localparam logic [4:0] KEY_1    = 5'b10001;
    localparam logic [4:0] KEY_2    = 5'b10010;
    localparam logic [4:0] KEY_3    = 5'b10011;
    localparam logic [4:0] KEY_4    = 5'b10100;
    localparam logic [4:0] KEY_5    = 5'b10101;
    localparam logic [4:0] KEY_6    = 5'b10110;
    localparam logic [4:0] KEY_7    = 5'b10111;
    localparam logic [4:0] KEY_8    = 5'b11000;
    localparam logic [4:0] KEY_9    = 5'b11001;
    localparam logic [4:0] KEY_A    = 5'b11010;
    localparam logic [4:0] KEY_B    = 5'b11011;
    localparam logic [4:0] KEY_C    = 5'b11100;
    localparam logic [4:0] KEY_D    = 5'b11101;
    localparam logic [4:0] KEY_STAR = 5'b11110;
    localparam logic [4:0] KEY_HASH = 5'b11111;

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} kp_state_e;

    // Element {row, col} is the code of the key at that matrix position.
    localparam logic [15:0][3:0] KEY_MAP = {
        4'd13, 4'd15, 4'd0, 4'd14,   // row 3: D # 0 *
        4'd12, 4'd9,  4'd8, 4'd7,    // row 2: C 9 8 7
        4'd11, 4'd6,  4'd5, 4'd4,    // row 1: B 6 5 4
        4'd10, 4'd3,  4'd2, 4'd1     // row 0: A 3 2 1
    };

    function automatic logic [4:0] key_pulse_code(input logic [1:0] row, input logic [1:0] col);
        return {1'b1, KEY_MAP[{row, col}]};
    endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchroniser for asynchronous inputs; resets to all-ones so that
// idle (pulled-up) keypad columns read as released.
module keypad_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner with debounce, one key_pulse per press.
// Define KEYPAD_KEY_REPEAT_EN to auto-repeat the pulse while a key stays held.
module keypad_scan
    import nonogram_pkg::*;
#(
    parameter int SCAN_DIV   = 1000,
    parameter int DB_CNT     = 10,
    parameter int REPEAT_DLY = 50,
    parameter int REPEAT_PER = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_col,
    output logic [3:0] key_row,
    output logic [4:0] key_pulse,
    output logic       key_held,
    output kp_state_e  fsm_state
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DB_CNT + 1);

    if (SCAN_DIV < 4) begin : g_bad_div
        $error("keypad_scan: SCAN_DIV must be at least 4");
    end
    if (DB_CNT < 1 || REPEAT_DLY < 1 || REPEAT_PER < 1) begin : g_bad_cnt
        $error("keypad_scan: DB_CNT, REPEAT_DLY and REPEAT_PER must be at least 1");
    end

    logic [3:0]       col_s;
    kp_state_e        state_q, state_d;
    logic [DIV_W-1:0] div_q;
    logic [1:0]       row_q, row_d, col_q, col_d, hit_col;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       pulse_q, pulse_d;
    logic             tick, key_down;

    keypad_sync #(.WIDTH(4)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (key_col),
        .q   (col_s)
    );

    assign tick     = (div_q == DIV_W'(SCAN_DIV - 1));
    assign key_down = ~col_s[col_q];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)      div_q <= '0;
        else if (tick) div_q <= '0;
        else           div_q <= div_q + DIV_W'(1);
    end

    // Lowest-index low column wins when several keys in a row are down.
    always_comb begin
        hit_col = 2'd3;
        for (int i = 3; i >= 0; i--) begin
            if (!col_s[i]) hit_col = 2'(i);
        end
    end

`ifdef KEYPAD_KEY_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    logic [REP_W-1:0] rep_q, rep_d, rep_target;
    logic             armed_q, armed_d;

    assign rep_target = armed_q ? REP_W'(REPEAT_PER) : REP_W'(REPEAT_DLY);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rep_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            rep_q   <= rep_d;
            armed_q <= armed_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        cnt_d   = cnt_q;
        pulse_d = KEY_NONE;
`ifdef KEYPAD_KEY_REPEAT_EN
        rep_d   = rep_q;
        armed_d = armed_q;
`endif
        if (tick) begin
            case (state_q)
                SCAN: begin
                    if (col_s == 4'b1111) begin
                        row_d = row_q + 2'd1;
                    end else begin
                        col_d = hit_col;
                        if (DB_CNT == 1) begin
                            state_d = HELD;
                            pulse_d = key_pulse_code(row_q, hit_col);
                        end else begin
                            state_d = DEBOUNCE;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                DEBOUNCE: begin
                    if (!key_down) begin
                        state_d = SCAN;
                        row_d   = row_q + 2'd1;
                    end else if (cnt_q == CNT_W'(DB_CNT - 1)) begin
                        state_d = HELD;
                        pulse_d = key_pulse_code(row_q, col_q);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                HELD: begin
                    if (!key_down) begin
                        if (DB_CNT == 1) begin
                            state_d = SCAN;
                            row_d   = row_q + 2'd1;
                        end else begin
                            state_d = RELEASE;
                            cnt_d   = CNT_W'(1);
                        end
                    end
`ifdef KEYPAD_KEY_REPEAT_EN
                    else if (rep_q + REP_W'(1) == rep_target) begin
                        pulse_d = key_pulse_code(row_q, col_q);
                        rep_d   = '0;
                        armed_d = 1'b1;
                    end else begin
                        rep_d = rep_q + REP_W'(1);
                    end
`endif
                end
                RELEASE: begin
                    // A low sample here is release bounce: back to HELD silently.
                    if (key_down) begin
                        state_d = HELD;
                    end else if (cnt_q == CNT_W'(DB_CNT - 1)) begin
                        state_d = SCAN;
                        row_d   = row_q + 2'd1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = SCAN;
            endcase
        end
`ifdef KEYPAD_KEY_REPEAT_EN
        if (state_d == HELD && (state_q == SCAN || state_q == DEBOUNCE)) begin
            rep_d   = '0;
            armed_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= SCAN;
            row_q   <= 2'd0;
            col_q   <= 2'd0;
            cnt_q   <= '0;
            pulse_q <= KEY_NONE;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign key_row   = ~(4'b0001 << row_q);
    assign key_pulse = pulse_q;
    assign key_held  = (state_q == HELD) || (state_q == RELEASE);
    assign fsm_state = state_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan: a keypad matrix model drives key_col from
// key_row, and a per-cycle checker matches pulses against an expected queue.
`timescale 1ns/1ps
module tb_keypad_scan;
    import nonogram_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] key_col, key_row;
    logic [4:0] key_pulse;
    logic       key_held;
    kp_state_e  fsm_state;

    logic [15:0] pressed = '0;   // bit r*4+c set while key (row r, col c) is down
    logic [4:0]  exp_q[$];
    int          n_cmp = 0, n_bad = 0;
    int          cyc;
    int          last_pulse_cyc = -1;
    logic [3:0]  prev_row   = 4'b1110;
    logic [4:0]  prev_pulse = '0;
    logic        prev_held  = 1'b0;
    int          c, p, k4_last;

    keypad_scan #(
        .SCAN_DIV   (4),
        .DB_CNT     (3),
        .REPEAT_DLY (6),
        .REPEAT_PER (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_col   (key_col),
        .key_row   (key_row),
        .key_pulse (key_pulse),
        .key_held  (key_held),
        .fsm_state (fsm_state)
    );

    // Clock / reset-relative cycle count (posedges since rst went high).
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    // Passive keypad matrix: a pressed key pulls its column low when its row is driven.
    always_comb begin
        key_col = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int col = 0; col < 4; col++) begin
                if (!key_row[r] && pressed[r*4 + col]) key_col[col] = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: rules every output must obey, and pulses popped from exp_q.
    always @(negedge clk) begin
        if (!rst) begin
            prev_row   <= 4'b1110;
            prev_pulse <= '0;
            prev_held  <= 1'b0;
        end else begin
            check("row_one_cold", 32'($countones(~key_row)), 1);
            if (key_row != prev_row) begin
                check("row_step", {28'b0, key_row}, {28'b0, prev_row[2:0], prev_row[3]});
                check("row_on_tick", cyc % 4, 0);
            end
            check("pulse_format", key_pulse[4] ? 32'd0 : {28'b0, key_pulse[3:0]}, 0);
            if (key_pulse != 5'b0) begin
                check("pulse_isolated", {27'b0, prev_pulse}, 0);
                check("held_with_pulse", {31'b0, key_held}, 1);
                if (exp_q.size() == 0) check("pulse_expected", {27'b0, key_pulse}, 0);
                else                   check("pulse_code", {27'b0, key_pulse}, {27'b0, exp_q.pop_front()});
                last_pulse_cyc <= cyc;
            end
            if (key_held && !prev_held) check("held_rise_on_pulse", {31'b0, key_pulse[4]}, 1);
            prev_row   <= key_row;
            prev_pulse <= key_pulse;
            prev_held  <= key_held;
        end
    end

    // Wait for the negedge right after the row advanced onto `row`.
    task automatic wait_aligned(input logic [3:0] row, output int at);
        bit found = 1'b0;
        at = 0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge clk);
            if (key_row == row && cyc % 4 == 0) begin
                found = 1'b1;
                at    = cyc;
            end
        end
        check("wait_row", {31'b0, found}, 1);
    endtask

    task automatic wait_phase(output int at);
        bit found = 1'b0;
        at = 0;
        for (int i = 0; i < 8 && !found; i++) begin
            @(negedge clk);
            if (cyc % 4 == 0) begin
                found = 1'b1;
                at    = cyc;
            end
        end
        check("wait_phase", {31'b0, found}, 1);
    endtask

    initial begin
        logic [3:0] idle_rows [4];
        idle_rows = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

        // Reset values, then idle rotation every 4 clk.
        repeat (3) @(negedge clk);
        check("rst_row", {28'b0, key_row}, 4'b1110);
        check("rst_pulse", {27'b0, key_pulse}, 0);
        check("rst_held", {31'b0, key_held}, 0);
        check("rst_state", 32'(fsm_state), 32'(SCAN));
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i % 4 == 0) check("idle_row", {28'b0, key_row}, {28'b0, idle_rows[(i / 4) % 4]});
            @(negedge clk);
        end

        // Clean press of key 2: pulse on the third tick sample, release after 3 ticks.
        wait_aligned(4'b1110, c);
        pressed[1] = 1'b1;
        exp_q.push_back(5'b10010);
        repeat (100) @(negedge clk);
        check("key2_latency", last_pulse_cyc, c + 12);
        check("key2_held", {31'b0, key_held}, 1);
        wait_phase(p);
        pressed[1] = 1'b0;
        repeat (11) @(negedge clk);
        check("key2_held_pre_release", {31'b0, key_held}, 1);
        @(negedge clk);
        check("key2_released", {31'b0, key_held}, 0);
        check("key2_queue", exp_q.size(), 0);

        // A and 3 together: column 2 wins; 8 on another row waits for the rescan.
        pressed[3] = 1'b1;
        pressed[2] = 1'b1;
        exp_q.push_back(5'b10011);
        exp_q.push_back(5'b11000);
        repeat (40) @(negedge clk);
        check("a3_single", exp_q.size(), 1);
        pressed[9] = 1'b1;
        repeat (60) @(negedge clk);
        check("eight_blocked", exp_q.size(), 1);
        check("three_held", {31'b0, key_held}, 1);
        pressed[2] = 1'b0;
        pressed[3] = 1'b0;
        repeat (80) @(negedge clk);
        check("eight_rescanned", exp_q.size(), 0);
        check("eight_held", {31'b0, key_held}, 1);
        pressed[9] = 1'b0;
        repeat (40) @(negedge clk);
        check("eight_released", {31'b0, key_held}, 0);

        // Key B bounces for one tick, then is stable.
        wait_aligned(4'b1101, c);
        pressed[7] = 1'b1;
        repeat (4) @(negedge clk);
        pressed[7] = 1'b0;
        repeat (4) @(negedge clk);
        pressed[7] = 1'b1;
        exp_q.push_back(5'b11011);
        repeat (40) @(negedge clk);
        check("keyb_latency", last_pulse_cyc, c + 8 + 24);
        check("keyb_queue", exp_q.size(), 0);
        pressed[7] = 1'b0;
        repeat (40) @(negedge clk);
        check("keyb_released", {31'b0, key_held}, 0);

        // Key 4 held for 20 ticks after its pulse.
        wait_aligned(4'b1101, c);
        pressed[4] = 1'b1;
        exp_q.push_back(5'b10100);
        k4_last = c + 12;
`ifdef KEYPAD_KEY_REPEAT_EN
        for (int k = 0; k < 7; k++) exp_q.push_back(5'b10100);
        k4_last = c + 12 + 4 * 18;
`endif
        repeat (88) @(negedge clk);
        pressed[4] = 1'b0;
        check("key4_last_pulse", last_pulse_cyc, k4_last);
        repeat (40) @(negedge clk);
        check("key4_queue", exp_q.size(), 0);
        check("key4_released", {31'b0, key_held}, 0);

        // Reset during DEBOUNCE of key 6; key still down afterwards pulses once.
        wait_aligned(4'b1101, c);
        pressed[6] = 1'b1;
        repeat (6) @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_row", {28'b0, key_row}, 4'b1110);
        check("midrst_pulse", {27'b0, key_pulse}, 0);
        check("midrst_held", {31'b0, key_held}, 0);
        check("midrst_state", 32'(fsm_state), 32'(SCAN));
        repeat (3) @(negedge clk);
        exp_q.push_back(5'b10110);
        rst = 1'b1;
        repeat (30) @(negedge clk);
        check("key6_latency", last_pulse_cyc, 16);
        check("key6_queue", exp_q.size(), 0);
        check("key6_held", {31'b0, key_held}, 1);
        pressed[6] = 1'b0;
        repeat (40) @(negedge clk);
        check("key6_released", {31'b0, key_held}, 0);

        check("final_queue", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
